// File: rtl/mips_datapath_fetch_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage:
// fetch FSM encoding, default widths, the {pc, instr} FIFO entry
// type and the FIFO occupancy-counter width helper.
package mips_datapath_fetch_pkg;

    // Default datapath geometry
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    localparam int FETCH_DEPTH  = 2;

    // Fetch FSM:
    //   IDLE  - no request outstanding; a request may be issued
    //   WAIT  - one request accepted, its response is still due
    //   DRAIN - request squashed by a redirect; its response is discarded
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // One buffered fetch result, address in the upper half
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0] pc;
        logic [FETCH_DATA_W-1:0] instr;
    } fetch_entry_t;

    // Occupancy counter must hold 0..DEPTH inclusive
    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/mips_datapath_fetch_fifo.sv
// Small circular FIFO holding fetched {pc, instr} pairs ahead of decode.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
// Clear has priority over push/pop. The caller never pushes when full
// and never pops when empty. Storage is zeroed on reset so the head
// reads as zero straight out of reset.
module mips_datapath_fetch_fifo
    import mips_datapath_fetch_pkg::*;
#(
    parameter int WIDTH = FETCH_ADDR_W + FETCH_DATA_W,
    parameter int DEPTH = FETCH_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = cnt_width(DEPTH)
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Occupancy next-state: simultaneous push and pop leaves it unchanged
    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: ;
        endcase
    end

    // Storage, pointers and occupancy; clear empties the queue in one cycle
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/mips_datapath_fetch.sv
// MIPS instruction-fetch stage, directly downstream of the PC register.
// Issues one instruction-memory read per PC over a valid/ready channel,
// pairs each response with the PC it was fetched from, buffers the pairs
// in a small FIFO ahead of decode and tells the PC when to advance.
// A redirect (flush) squashes buffered entries and any outstanding fetch.
//
// Handshakes: a transfer happens on a cycle where valid & ready are both
// high. memReqValid, once raised, stays high until accepted (the PC is
// held meanwhile, so the address is stable); outValid/outPc/outInstr
// hold while outValid & !outReady. Flush overrides both channels in its
// cycle: no request is issued and no entry is popped or pushed.
//
// Build option MIPS_DATAPATH_FETCH_BYPASS_EN: when defined, a live
// response arriving while the FIFO is empty is shown on the decode side
// in the same cycle, and skips the FIFO entirely if decode takes it.
// When undefined, every response goes through the FIFO (1-cycle latency).
//
// dbgState exposes the fetch FSM state for observation.
module mips_datapath_fetch
    import mips_datapath_fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic [ADDR_W-1:0] pcAddr,
    output logic              pcAdvance,
    input  logic              flush,
    output logic              memReqValid,
    input  logic              memReqReady,
    output logic [ADDR_W-1:0] memReqAddr,
    input  logic              memRespValid,
    input  logic [DATA_W-1:0] memRespData,
    output logic              outValid,
    input  logic              outReady,
    output logic [DATA_W-1:0] outInstr,
    output logic [ADDR_W-1:0] outPc,
    output logic [1:0]        dbgState
);

    localparam int ENTRY_W = ADDR_W + DATA_W;
    localparam int CNT_W   = cnt_width(DEPTH);

    fetch_state_e      state_q;
    logic [ADDR_W-1:0] req_pc_q;

    logic              req_valid;
    logic              req_fire;
    logic              resp_live;
    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_has;
    logic [CNT_W-1:0]  fifo_count;
    logic [ENTRY_W-1:0] fifo_head;
    logic [ENTRY_W-1:0] resp_entry;
    logic              out_valid;
    logic [ADDR_W-1:0] out_pc;
    logic [DATA_W-1:0] out_instr;

    // Response paired with the PC latched when its request was accepted
    assign resp_entry = {req_pc_q, memRespData};

    // Request issue, PC advance, FIFO control and the decode-side view
    always_comb begin
        // Only one request in flight, and only when a FIFO slot is free for
        // its response; resetN gates it so the channel is quiet in reset.
        req_valid = resetN & (state_q == ST_IDLE) & ~flush & ~fifo_full;
        req_fire  = req_valid & memReqReady;

        // A response that will be kept: arrived in WAIT and not squashed
        resp_live = (state_q == ST_WAIT) & memRespValid & ~flush;
        fifo_has  = (fifo_count != '0);
        fifo_pop  = fifo_has & outReady & ~flush;

`ifdef MIPS_DATAPATH_FETCH_BYPASS_EN
        // Empty FIFO: forward the live response straight to decode, and
        // only buffer it when decode does not take it this cycle.
        out_valid = fifo_has | (resp_live & fifo_empty);
        if (fifo_has) begin
            out_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
            out_instr = fifo_head[DATA_W-1:0];
        end else if (resp_live) begin
            out_pc    = req_pc_q;
            out_instr = memRespData;
        end else begin
            out_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
            out_instr = fifo_head[DATA_W-1:0];
        end
        fifo_push = resp_live & ~(fifo_empty & outReady);
`else
        // Every live response is buffered; decode always sees the FIFO head
        out_valid = fifo_has;
        out_pc    = fifo_head[ENTRY_W-1 -: ADDR_W];
        out_instr = fifo_head[DATA_W-1:0];
        fifo_push = resp_live;
`endif
    end

    // Fetch FSM plus the request-PC latch captured at each handshake
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q  <= ST_IDLE;
            req_pc_q <= '0;
        end else begin
            if (req_fire) begin
                req_pc_q <= pcAddr;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // A response in the flush cycle is dropped but still
                    // retires the request; otherwise wait it out in DRAIN.
                    if (memRespValid) begin
                        state_q <= ST_IDLE;
                    end else if (flush) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (memRespValid) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    mips_datapath_fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock       (clock),
        .resetN      (resetN),
        .clear_i     (flush),
        .push_i      (fifo_push),
        .push_data_i (resp_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign memReqValid = req_valid;
    assign memReqAddr  = pcAddr;
    assign pcAdvance   = req_fire;
    assign outValid    = out_valid;
    assign outPc       = out_pc;
    assign outInstr    = out_instr;
    assign dbgState    = state_q;

endmodule

// File: tb/tb_mips_datapath_fetch.sv
// Testbench for mips_datapath_fetch: directed scenarios followed by a
// randomized stream checked against a transaction-level model (PC
// register, single-request memory and an expected decode queue).
module tb_mips_datapath_fetch;
    import mips_datapath_fetch_pkg::*;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;
`ifdef MIPS_DATAPATH_FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clock;
    logic              resetN;
    logic [ADDR_W-1:0] pcAddr;
    logic              pcAdvance;
    logic              flush;
    logic              memReqValid;
    logic              memReqReady;
    logic [ADDR_W-1:0] memReqAddr;
    logic              memRespValid;
    logic [DATA_W-1:0] memRespData;
    logic              outValid;
    logic              outReady;
    logic [DATA_W-1:0] outInstr;
    logic [ADDR_W-1:0] outPc;
    logic [1:0]        dbgState;

    int checks   = 0;
    int failures = 0;

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    mips_datapath_fetch #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clock        (clock),
        .resetN       (resetN),
        .pcAddr       (pcAddr),
        .pcAdvance    (pcAdvance),
        .flush        (flush),
        .memReqValid  (memReqValid),
        .memReqReady  (memReqReady),
        .memReqAddr   (memReqAddr),
        .memRespValid (memRespValid),
        .memRespData  (memRespData),
        .outValid     (outValid),
        .outReady     (outReady),
        .outInstr     (outInstr),
        .outPc        (outPc),
        .dbgState     (dbgState)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h8C08_0000;
    endfunction

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset;
        resetN       = 1'b0;
        flush        = 1'b0;
        memReqReady  = 1'b0;
        memRespValid = 1'b0;
        memRespData  = '0;
        outReady     = 1'b0;
        pcAddr       = 32'h0040_0000;
        repeat (2) @(posedge clock);
        #1;
        resetN = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        resetN = 1'b0; flush = 1'b0; memReqReady = 1'b1; memRespValid = 1'b0;
        memRespData = '0; outReady = 1'b0; pcAddr = 32'h0040_0000;
        @(negedge clock);
        checks++; if (memReqValid !== 1'b0) begin failures++; $display("FAIL reset_req_valid: got %b want 0", memReqValid); end
        checks++; if (pcAdvance !== 1'b0) begin failures++; $display("FAIL reset_pc_advance: got %b want 0", pcAdvance); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b want 0", outValid); end
        checks++; if (outInstr !== 32'h0) begin failures++; $display("FAIL reset_out_instr: got %h want 0", outInstr); end
        checks++; if (outPc !== 32'h0) begin failures++; $display("FAIL reset_out_pc: got %h want 0", outPc); end
        checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", dbgState, ST_IDLE); end
    endtask

    task automatic test_basic_fetch;
        logic        exp_ov;
        logic [31:0] exp_pc;
        apply_reset;
        memReqReady = 1'b1;
        @(negedge clock);
        checks++; if (memReqValid !== 1'b1) begin failures++; $display("FAIL basic_req_valid: got %b want 1", memReqValid); end
        checks++; if (memReqAddr !== 32'h0040_0000) begin failures++; $display("FAIL basic_req_addr: got %h want 00400000", memReqAddr); end
        checks++; if (pcAdvance !== 1'b1) begin failures++; $display("FAIL basic_pc_advance: got %b want 1", pcAdvance); end
        next_cycle;
        pcAddr = 32'h0040_0004; memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'h8C08_0000;
        @(negedge clock);
        exp_ov = BYPASS;
        exp_pc = BYPASS ? 32'h0040_0000 : 32'h0;
        checks++; if (memReqValid !== 1'b0) begin failures++; $display("FAIL basic_wait_req_valid: got %b want 0", memReqValid); end
        checks++; if (outValid !== exp_ov) begin failures++; $display("FAIL basic_resp_cycle_out_valid: got %b want %b", outValid, exp_ov); end
        checks++; if (outPc !== exp_pc) begin failures++; $display("FAIL basic_resp_cycle_out_pc: got %h want %h", outPc, exp_pc); end
        next_cycle;
        memRespValid = 1'b0;
        @(negedge clock);
        checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL basic_out_valid: got %b want 1", outValid); end
        checks++; if (outPc !== 32'h0040_0000) begin failures++; $display("FAIL basic_out_pc: got %h want 00400000", outPc); end
        checks++; if (outInstr !== 32'h8C08_0000) begin failures++; $display("FAIL basic_out_instr: got %h want 8c080000", outInstr); end
        checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL basic_state_idle: got %0d want %0d", dbgState, ST_IDLE); end
        checks++; if (memReqAddr !== 32'h0040_0004 || memReqValid !== 1'b1) begin failures++; $display("FAIL basic_next_req: got valid=%b addr=%h want 1/00400004", memReqValid, memReqAddr); end
    endtask

    task automatic test_ready_stall;
        apply_reset;
        memReqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (memReqValid !== 1'b1) begin failures++; $display("FAIL stall_req_valid[%0d]: got %b want 1", i, memReqValid); end
            checks++; if (memReqAddr !== 32'h0040_0000) begin failures++; $display("FAIL stall_req_addr[%0d]: got %h want 00400000", i, memReqAddr); end
            checks++; if (pcAdvance !== 1'b0) begin failures++; $display("FAIL stall_pc_advance[%0d]: got %b want 0", i, pcAdvance); end
            next_cycle;
        end
        memReqReady = 1'b1;
        @(negedge clock);
        checks++; if (pcAdvance !== 1'b1) begin failures++; $display("FAIL stall_release_advance: got %b want 1", pcAdvance); end
        next_cycle;
        memReqReady = 1'b0;
        @(negedge clock);
        checks++; if (dbgState !== ST_WAIT) begin failures++; $display("FAIL stall_state_wait: got %0d want %0d", dbgState, ST_WAIT); end
    endtask

    task automatic test_fill_full;
        logic [31:0] pc, pend_addr;
        bit          pend, exp_rv;
        apply_reset;
        pc = 32'h0040_0000; pend = 1'b0; pend_addr = '0;
        for (int i = 0; i < 6; i++) begin
            pcAddr = pc; memReqReady = 1'b1; outReady = 1'b0;
            memRespValid = pend; memRespData = mem_word(pend_addr);
            @(negedge clock);
            exp_rv = (i == 0) || (i == 2);
            checks++; if (memReqValid !== exp_rv) begin failures++; $display("FAIL fill_req_valid[%0d]: got %b want %b", i, memReqValid, exp_rv); end
            if (pend) pend = 1'b0;
            else if (exp_rv) begin pend = 1'b1; pend_addr = pc; pc = pc + 4; end
            next_cycle;
        end
        pcAddr = pc; memReqReady = 1'b0; memRespValid = 1'b0; outReady = 1'b1;
        @(negedge clock);
        checks++; if (outValid !== 1'b1 || outPc !== 32'h0040_0000) begin failures++; $display("FAIL fill_head0: got valid=%b pc=%h want 1/00400000", outValid, outPc); end
        checks++; if (outInstr !== mem_word(32'h0040_0000)) begin failures++; $display("FAIL fill_instr0: got %h want %h", outInstr, mem_word(32'h0040_0000)); end
        checks++; if (memReqValid !== 1'b0) begin failures++; $display("FAIL fill_full_no_req: got %b want 0", memReqValid); end
        next_cycle;
        @(negedge clock);
        checks++; if (outValid !== 1'b1 || outPc !== 32'h0040_0004) begin failures++; $display("FAIL fill_head1: got valid=%b pc=%h want 1/00400004", outValid, outPc); end
        checks++; if (outInstr !== mem_word(32'h0040_0004)) begin failures++; $display("FAIL fill_instr1: got %h want %h", outInstr, mem_word(32'h0040_0004)); end
        checks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h0040_0008) begin failures++; $display("FAIL fill_resume: got valid=%b addr=%h want 1/00400008", memReqValid, memReqAddr); end
        next_cycle;
        @(negedge clock);
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL fill_drained: got %b want 0", outValid); end
        outReady = 1'b0;
    endtask

    task automatic test_flush_wait;
        apply_reset;
        memReqReady = 1'b1;
        @(negedge clock);
        checks++; if (pcAdvance !== 1'b1) begin failures++; $display("FAIL fw_issue: got %b want 1", pcAdvance); end
        next_cycle;
        pcAddr = 32'h0040_0004; flush = 1'b1;
        @(negedge clock);
        checks++; if (memReqValid !== 1'b0 || pcAdvance !== 1'b0) begin failures++; $display("FAIL fw_flush_no_req: got valid=%b adv=%b want 0/0", memReqValid, pcAdvance); end
        next_cycle;
        flush = 1'b0; pcAddr = 32'h0050_0000;
        @(negedge clock);
        checks++; if (dbgState !== ST_DRAIN) begin failures++; $display("FAIL fw_state_drain: got %0d want %0d", dbgState, ST_DRAIN); end
        checks++; if (memReqValid !== 1'b0) begin failures++; $display("FAIL fw_drain_no_req: got %b want 0", memReqValid); end
        next_cycle;
        memRespValid = 1'b1; memRespData = 32'hDEAD_BEEF;
        @(negedge clock);
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL fw_resp_discarded: got %b want 0", outValid); end
        checks++; if (memReqValid !== 1'b0) begin failures++; $display("FAIL fw_resp_cycle_no_req: got %b want 0", memReqValid); end
        next_cycle;
        memRespValid = 1'b0;
        @(negedge clock);
        checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL fw_state_idle: got %0d want %0d", dbgState, ST_IDLE); end
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL fw_no_out: got %b want 0", outValid); end
        checks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h0050_0000) begin failures++; $display("FAIL fw_refetch: got valid=%b addr=%h want 1/00500000", memReqValid, memReqAddr); end
    endtask

    task automatic test_flush_pop_resp;
        apply_reset;
        memReqReady = 1'b1;
        next_cycle;
        memReqReady = 1'b0; memRespValid = 1'b1; memRespData = mem_word(32'h0040_0000); pcAddr = 32'h0040_0004;
        next_cycle;
        memRespValid = 1'b0; memReqReady = 1'b1;
        @(negedge clock);
        checks++; if (outValid !== 1'b1) begin failures++; $display("FAIL fp_buffered: got %b want 1", outValid); end
        next_cycle;
        pcAddr = 32'h0040_0008; memRespValid = 1'b1; memRespData = mem_word(32'h0040_0004);
        flush = 1'b1; outReady = 1'b1;
        @(negedge clock);
        checks++; if (pcAdvance !== 1'b0 || memReqValid !== 1'b0) begin failures++; $display("FAIL fp_flush_cycle_req: got adv=%b valid=%b want 0/0", pcAdvance, memReqValid); end
        next_cycle;
        flush = 1'b0; memRespValid = 1'b0; outReady = 1'b0; memReqReady = 1'b0; pcAddr = 32'h0060_0000;
        @(negedge clock);
        checks++; if (outValid !== 1'b0) begin failures++; $display("FAIL fp_fifo_empty: got %b want 0", outValid); end
        checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL fp_state_idle: got %0d want %0d", dbgState, ST_IDLE); end
        checks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h0060_0000) begin failures++; $display("FAIL fp_refetch: got valid=%b addr=%h want 1/00600000", memReqValid, memReqAddr); end
    endtask

    task automatic test_async_reset;
        apply_reset;
        memReqReady = 1'b1;
        next_cycle;
        memReqReady = 1'b0; memRespValid = 1'b1; memRespData = mem_word(32'h0040_0000); pcAddr = 32'h0040_0004;
        next_cycle;
        memRespValid = 1'b0; memReqReady = 1'b1;
        next_cycle;
        memReqReady = 1'b0; pcAddr = 32'h0040_0008;
        #1;
        checks++; if (outValid !== 1'b1 || dbgState !== ST_WAIT) begin failures++; $display("FAIL ar_pre_state: got valid=%b state=%0d want 1/%0d", outValid, dbgState, ST_WAIT); end
        resetN = 1'b0;
        #1;
        checks++; if (outValid !== 1'b0 || memReqValid !== 1'b0) begin failures++; $display("FAIL ar_immediate: got out=%b req=%b want 0/0", outValid, memReqValid); end
        checks++; if (dbgState !== ST_IDLE) begin failures++; $display("FAIL ar_state: got %0d want %0d", dbgState, ST_IDLE); end
        next_cycle;
        resetN = 1'b1; pcAddr = 32'h0040_0000; memReqReady = 1'b1;
        @(negedge clock);
        checks++; if (memReqValid !== 1'b1 || memReqAddr !== 32'h0040_0000 || pcAdvance !== 1'b1) begin failures++; $display("FAIL ar_restart_req: got valid=%b addr=%h adv=%b want 1/00400000/1", memReqValid, memReqAddr, pcAdvance); end
        next_cycle;
        memReqReady = 1'b0; memRespValid = 1'b1; memRespData = 32'h8C08_0000; pcAddr = 32'h0040_0004;
        next_cycle;
        memRespValid = 1'b0;
        @(negedge clock);
        checks++; if (outValid !== 1'b1 || outPc !== 32'h0040_0000 || outInstr !== 32'h8C08_0000) begin failures++; $display("FAIL ar_restart_out: got valid=%b pc=%h instr=%h want 1/00400000/8c080000", outValid, outPc, outInstr); end
    endtask

    // Random traffic against a model of PC register, memory and decode queue
    task automatic test_random_stream;
        logic [ADDR_W+DATA_W-1:0] exp_q[$];
        logic [ADDR_W+DATA_W-1:0] exp_head;
        logic [31:0] pc_m, out_addr;
        bit          outstanding, live, exp_rv, live_resp, byp, exp_ov, consumed;
        int          delay;
        apply_reset;
        pc_m = 32'h0040_0000; out_addr = '0; outstanding = 1'b0; live = 1'b0; delay = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            pcAddr       = pc_m;
            flush        = ($urandom_range(0, 15) == 0);
            memReqReady  = ($urandom_range(0, 3) != 0);
            outReady     = ($urandom_range(0, 2) != 0);
            memRespValid = 1'b0;
            memRespData  = $urandom;
            if (outstanding) begin
                if (delay == 0) begin
                    memRespValid = 1'b1;
                    memRespData  = mem_word(out_addr);
                end else begin
                    delay--;
                end
            end
            @(negedge clock);
            exp_rv    = !outstanding && !flush && (exp_q.size() < DEPTH);
            live_resp = memRespValid && live && !flush;
            byp       = BYPASS && live_resp && (exp_q.size() == 0);
            exp_ov    = (exp_q.size() != 0) || byp;
            checks++; if (memReqValid !== exp_rv) begin failures++; $display("FAIL rnd_req_valid@%0d: got %b want %b", cyc, memReqValid, exp_rv); end
            if (exp_rv) begin
                checks++; if (memReqAddr !== pc_m) begin failures++; $display("FAIL rnd_req_addr@%0d: got %h want %h", cyc, memReqAddr, pc_m); end
            end
            checks++; if (pcAdvance !== (exp_rv && memReqReady)) begin failures++; $display("FAIL rnd_pc_advance@%0d: got %b want %b", cyc, pcAdvance, exp_rv && memReqReady); end
            checks++; if (outValid !== exp_ov) begin failures++; $display("FAIL rnd_out_valid@%0d: got %b want %b", cyc, outValid, exp_ov); end
            if (exp_ov) begin
                exp_head = (exp_q.size() != 0) ? exp_q[0] : {out_addr, mem_word(out_addr)};
                checks++; if ({outPc, outInstr} !== exp_head) begin failures++; $display("FAIL rnd_out_data@%0d: got %h/%h want %h/%h", cyc, outPc, outInstr, exp_head[63:32], exp_head[31:0]); end
            end
            if (flush) begin
                exp_q.delete();
                if (memRespValid) outstanding = 1'b0;
                else live = 1'b0;
                pc_m = $urandom & 32'hFFFF_FFFC;
            end else begin
                consumed = exp_ov && outReady;
                if (consumed && exp_q.size() != 0) void'(exp_q.pop_front());
                if (live_resp && !(byp && consumed)) exp_q.push_back({out_addr, mem_word(out_addr)});
                if (memRespValid) outstanding = 1'b0;
            end
            if (exp_rv && memReqReady) begin
                outstanding = 1'b1;
                live        = 1'b1;
                out_addr    = pc_m;
                delay       = $urandom_range(0, 2);
                pc_m        = pc_m + 4;
            end
            next_cycle;
        end
        flush = 1'b0; memReqReady = 1'b0; memRespValid = 1'b0; outReady = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset;
        test_basic_fetch;
        test_ready_stall;
        test_fill_full;
        test_flush_wait;
        test_flush_pop_resp;
        test_async_reset;
        test_random_stream;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
